// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory read-modify-write controller.
package dmem_pkg;

  localparam int DMEM_ADDR_WIDTH = 8;
  localparam int DMEM_DATA_WIDTH = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_DATA,
    ST_WR
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: extracts and extends sub-word load data, and merges
// sub-word store data into a previously read word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_sh   = {addr_lo_i, 3'b000};
  assign half_sh   = {addr_lo_i[1], 4'b0000};
  assign lane_b    = 8'(word_i >> byte_sh);
  assign lane_h    = 16'(word_i >> half_sh);
  assign byte_mask = 32'h0000_00FF << byte_sh;
  assign half_mask = 32'h0000_FFFF << half_sh;

  // Word size (and the never-used illegal size) passes data straight through.
  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_B: begin
        load_o  = {{24{lane_b[7] & ~unsigned_i}}, lane_b};
        merge_o = (word_i & ~byte_mask) | ({24'd0, wdata_i[7:0]} << byte_sh);
      end
      SZ_H: begin
        load_o  = {{16{lane_h[15] & ~unsigned_i}}, lane_h};
        merge_o = (word_i & ~half_mask) | ({16'd0, wdata_i[15:0]} << half_sh);
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// RV32I load/store front end for a single-port SRAM without byte write mask:
// sub-word stores become read-modify-write, loads are lane-extracted and extended.
module dmem_rmw_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  state_e                state_q;
  logic                  we_q;
  logic                  uns_q;
  logic [1:0]            lane_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wbuf_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  out_of_range;
  logic                  misaligned;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  assign out_of_range = |(req_addr >> (ADDR_WIDTH + 2));
  assign misaligned   = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign req_bad      = out_of_range || misaligned || (req_size == 2'd3);

  dmem_lane_align u_align (
    .addr_lo_i  (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .word_i     (sram_dout0),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= SZ_B;
      addr_q      <= '0;
      wdata_q     <= '0;
      wbuf_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            size_q  <= req_size;
            addr_q  <= req_addr[ADDR_WIDTH+1:2];
            wdata_q <= req_wdata;
            // Illegal requests are answered on the accept edge without touching the SRAM.
            if (req_bad) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (req_we && (req_size == SZ_W)) begin
              wbuf_q  <= req_wdata;
              state_q <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: state_q <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (we_q) begin
            wbuf_q  <= merge_data;
            state_q <= ST_WR;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_data;
            state_q     <= ST_IDLE;
          end
        end
        ST_WR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign sram_csb0  = !((state_q == ST_RD) || (state_q == ST_WR));
  assign sram_web0  = (state_q != ST_WR);
  assign sram_addr0 = addr_q;
  assign sram_din0  = wbuf_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: doc/dmem_rmw_ctrl.md
# dmem_rmw_ctrl

Core-facing data-memory controller that sits directly upstream of the 256x32 single-port OpenRAM data SRAM. It accepts RV32I load/store requests through a valid/ready handshake and drives the SRAM port. Because the SRAM has no byte write mask, it turns byte and halfword stores into read-modify-write sequences. It also extracts and sign-extends sub-word load data and flags misaligned or out-of-range accesses.

## Interface
- ADDR_WIDTH, 8, SRAM word-address width; the SRAM covers byte addresses 0 to 4*2^ADDR_WIDTH-1.
- DATA_WIDTH, 32, fixed word width; other values are unsupported.

Ports:
- clk0  in  1  single clock; the SRAM uses the same clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; the core cannot stall it.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal size; qualified by rsp_valid.
- sram_csb0  out  1  SRAM chip select, active low.
- sram_web0  out  1  SRAM write enable, active low.
- sram_addr0  out  ADDR_WIDTH  SRAM word address, req_addr[ADDR_WIDTH+1:2].
- sram_din0  out  32  SRAM write data.
- sram_dout0  in  32  SRAM read data, valid in the cycle after the read is sampled.

## Operation
- FSM states: IDLE, RD, RD_DATA, WR.
- SRAM controls decode from registered state and registered request only.
  - csb0 = 0 in RD and WR, 1 otherwise.
  - web0 = 0 only in WR.
- IDLE: request accepted on an edge with req_valid && req_ready. The whole request is captured into registers at that edge.
- Error check at accept: any of the following sets rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 on the accept edge. The FSM stays in IDLE and the SRAM is never selected.
  - req_size == 3.
  - half with addr[0] != 0.
  - word with addr[1:0] != 0.
  - req_addr[31:ADDR_WIDTH+2] != 0.
- State transitions after a legal accept:
  - Load: go to RD.
  - Word store: go to WR with din = wdata.
  - Byte or half store: go to RD (read half of the RMW).
- RD: SRAM read command is driven for one cycle, then go to RD_DATA.
- RD_DATA: sram_dout0 is sampled at the closing edge.
  - Load: extract the lane, extend, register into rsp_rdata, pulse rsp_valid, go to IDLE.
  - RMW store: merge wdata into the lane and register the result into the write buffer, go to WR.
- Lane rules:
  - Byte lane is addr[1:0]; halfword lane is addr[1]. Unselected bytes keep the read value.
  - Extension uses bit 7 (byte) or bit 15 (half) unless req_unsigned is set.
- WR: SRAM write command is driven for one cycle, then go to IDLE and pulse rsp_valid with rsp_err = 0 and rsp_rdata = 0.
- Back-to-back: a new request may be accepted in the same IDLE cycle in which rsp_valid is high.

## Timing
- Latency is measured from accept edge E0 to the edge on which rsp_valid rises:
  - Error: E0.
  - Word store: E1.
  - Load: E2.
  - Byte/half store: E3.
- rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err hold until the next response.
- The SRAM samples its command at the edge that ends RD or WR. Read data is used only at the edge that ends RD_DATA.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, sram_csb0 1, sram_web0 1, sram_addr0 0, sram_din0 0.
- Reset mid-operation:
  - csb0/web0 return to 1 asynchronously and no response is issued.
  - An RMW aborted before WR never writes.
  - A write in WR when reset asserts has an undefined outcome at the SRAM.
- req_* inputs are ignored outside the accept edge.

## Structure
- dmem_pkg holds:
  - the size encoding constants (SZ_B, SZ_H, SZ_W);
  - the state enum;
  - the width parameters.
- Sub-module dmem_lane_align is combinational. It provides load extract/extend and store merge from addr[1:0], size, unsigned, word_in and wdata. It is unit-testable on its own.
- The FSM, request registers and write buffer stay in dmem_rmw_ctrl.

## Test plan
- Reset: with rst_n low mid-cycle, all outputs take their reset values immediately and req_ready = 1.
- Word store then word load:
  - sw 0xDEADBEEF @0x100 gives a WR cycle with addr0 = 0x40 and rsp at E1.
  - lw @0x100 gives rsp_rdata = 0xDEADBEEF at E2.
- Byte RMW: sb 0xA5 @0x101 over 0xDEADBEEF gives RD, RD_DATA, then WR with din0 = 0xDEADA5EF and rsp at E3.
  - lb @0x101 returns 0xFFFFFFA5.
  - lbu @0x101 returns 0x000000A5.
- Half RMW: sh 0x1234 @0x102 gives din0 = 0x1234A5EF.
  - lh @0x102 returns 0x00001234.
  - lhu @0x100 returns 0x0000A5EF.
- Errors: each case gives rsp_err = 1 at E0, rsp_rdata = 0, and csb0 never low.
  - lw @0x102.
  - sh @0x101.
  - lw @0x400.
  - size 3.
- Reset in RD_DATA of sb @0x104: no WR cycle occurs, and a subsequent lw @0x104 returns the old word.
- Back-to-back: a second request held valid is accepted in the cycle rsp_valid pulses, and responses arrive in order.
